// File: rtl/sigdel_seq.sv
// sigdel_seq: sample sequencer feeding the 8-bit sigma-delta modulator input.
//
// Holds a DEPTH-entry pattern table plus div/len/loop config. On start the
// table is played out one entry at a time, each entry held for div+1 clocks,
// either once (done pulse at the end) or looped. IDLE_CODE is driven whenever
// playback is not running.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   ena            enable; low freezes the sequencer (config writes still land)
//   cfg_we/addr/data  config write port: 0..DEPTH-1 table, 8 div, 9 len, 10 loop
//   start, stop    playback control (stop wins over start)
//   sample_out     sample to the modulator
//   sample_valid   one-cycle pulse when sample_out takes a new table value
//   busy           high while playing
//   idx            index of the entry currently driven
//   done           one-cycle pulse on the natural end of one-shot playback
module sigdel_seq #(
    parameter int              DEPTH     = 8,
    parameter int              AW        = 3,
    parameter int              DW        = 8,
    parameter int              DIVW      = 8,
    parameter logic [DW-1:0]   IDLE_CODE = 8'h80
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic          start,
    input  logic          stop,
    output logic [DW-1:0] sample_out,
    output logic          sample_valid,
    output logic          busy,
    output logic [AW-1:0] idx,
    output logic          done
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   tbl_q [DEPTH];
    logic [DW-1:0]   tbl_d [DEPTH];
    logic [DIVW-1:0] div_q, div_d;
    logic [AW-1:0]   len_q, len_d;
    logic            loop_q, loop_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   sample_q, sample_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic [AW-1:0]   idx_inc;

    assign idx_inc = idx_q + AW'(1);

    // Config writes: table entries are always writable; playback params are
    // locked while running so an in-flight sequence keeps consistent timing.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) tbl_d[i] = tbl_q[i];
        div_d  = div_q;
        len_d  = len_q;
        loop_d = loop_q;
        if (cfg_we) begin
            if (cfg_addr < 4'(DEPTH)) begin
                tbl_d[cfg_addr[AW-1:0]] = cfg_data;
            end else if (state_q != S_RUN) begin
                case (cfg_addr)
                    4'd8:    div_d  = DIVW'(cfg_data);
                    4'd9:    len_d  = cfg_data[AW-1:0];
                    4'd10:   loop_d = cfg_data[0];
                    default: ;
                endcase
            end
        end
    end

    // Sequencer. With ena low everything holds and the pulses drop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    sample_d = IDLE_CODE;
                    idx_d    = '0;
                    cnt_d    = '0;
                    if (start && !stop) begin
                        state_d  = S_RUN;
                        sample_d = tbl_q[0];
                        valid_d  = 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d  = S_IDLE;
                        sample_d = IDLE_CODE;
                        idx_d    = '0;
                        cnt_d    = '0;
                    end else if (cnt_q < div_q) begin
                        cnt_d = cnt_q + DIVW'(1);
                    end else begin
                        cnt_d = '0;
                        if (idx_q < len_q) begin
                            idx_d    = idx_inc;
                            sample_d = tbl_q[idx_inc];
                            valid_d  = 1'b1;
                        end else if (loop_q) begin
                            idx_d    = '0;
                            sample_d = tbl_q[0];
                            valid_d  = 1'b1;
                        end else begin
                            state_d  = S_IDLE;
                            idx_d    = '0;
                            sample_d = IDLE_CODE;
                            done_d   = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= IDLE_CODE;
            div_q    <= '0;
            len_q    <= AW'(DEPTH - 1);
            loop_q   <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            sample_q <= IDLE_CODE;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= tbl_d[i];
            div_q    <= div_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign sample_out   = sample_q;
    // Pulses are masked by ena so nothing is announced while frozen.
    assign sample_valid = valid_q & ena;
    assign done         = done_q & ena;
    assign busy         = (state_q == S_RUN);
    assign idx          = idx_q;

endmodule

// File: tb/tb_sigdel_seq.sv
// Directed bench for sigdel_seq: reset/idle, one-shot and looped playback,
// stop, config lock while busy, ena freeze, len=0 loop, async reset mid-run.
module tb_sigdel_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       busy;
    logic [2:0] idx;
    logic       done;

    int tests = 0;
    int fails = 0;
    int nbusy;
    int j;
    logic [7:0] mdl [4];

    sigdel_seq dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .stop(stop),
        .sample_out(sample_out), .sample_valid(sample_valid),
        .busy(busy), .idx(idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    // Expected outputs for a div=2, len=3, one-shot run, j clocks after start.
    task automatic check_obs(input int jj, input logic en, input string tag);
        if (jj < 12) begin
            chk({tag, ".sample"}, sample_out, mdl[jj/3]);
            chk({tag, ".busy"},   busy, 1);
            chk({tag, ".idx"},    idx, jj/3);
            chk({tag, ".valid"},  sample_valid, en && (jj % 3 == 0));
            chk({tag, ".done"},   done, 0);
        end else begin
            chk({tag, ".sample"}, sample_out, 8'h80);
            chk({tag, ".busy"},   busy, 0);
            chk({tag, ".idx"},    idx, 0);
            chk({tag, ".valid"},  sample_valid, 0);
            chk({tag, ".done"},   done, en && (jj == 12));
        end
    endtask

    initial begin
        // reset held
        step(); step();
        chk("rst.sample", sample_out, 8'h80);
        chk("rst.busy", busy, 0);
        chk("rst.idx", idx, 0);
        chk("rst.valid", sample_valid, 0);
        chk("rst.done", done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle.sample", sample_out, 8'h80);
            chk("idle.busy", busy, 0);
            chk("idle.idx", idx, 0);
        end

        // one-shot, div=2, len=3
        mdl[0] = 8'd10; mdl[1] = 8'd20; mdl[2] = 8'd30; mdl[3] = 8'd40;
        wr(4'd0, 8'd10); wr(4'd1, 8'd20); wr(4'd2, 8'd30); wr(4'd3, 8'd40);
        wr(4'd8, 8'd2); wr(4'd9, 8'd3); wr(4'd10, 8'd0);
        start = 1'b1; step(); start = 1'b0;
        check_obs(0, 1'b1, "oneshot");
        for (int k = 1; k <= 13; k++) begin
            step();
            check_obs(k, 1'b1, "oneshot");
        end

        // looped, div=0, then stop mid-sequence
        wr(4'd10, 8'd1); wr(4'd8, 8'd0);
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            chk("loop.sample", sample_out, mdl[k % 4]);
            chk("loop.idx", idx, k % 4);
            chk("loop.valid", sample_valid, 1);
        end
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop.sample", sample_out, 8'h80);
        chk("stop.busy", busy, 0);
        chk("stop.idx", idx, 0);
        chk("stop.done", done, 0);
        step();
        chk("stop.done2", done, 0);

        // writes during RUN: div locked, table write lands, start ignored
        wr(4'd10, 8'd0); wr(4'd8, 8'd2);
        start = 1'b1; step(); start = 1'b0;
        mdl[2] = 8'd99;
        check_obs(0, 1'b1, "runwr");
        for (int k = 1; k <= 13; k++) begin
            if (k == 1) begin cfg_we = 1'b1; cfg_addr = 4'd8; cfg_data = 8'd5; end
            if (k == 2) begin cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 8'd99; end
            if (k == 3) start = 1'b1;
            step();
            cfg_we = 1'b0; start = 1'b0;
            check_obs(k, 1'b1, "runwr");
        end

        // ena freeze for 4 clocks while holding table[1]
        start = 1'b1; step(); start = 1'b0;
        j = 0; nbusy = 0;
        check_obs(0, 1'b1, "ena");
        nbusy += busy;
        for (int s = 1; s <= 17; s++) begin
            ena = !(s >= 4 && s <= 7);
            step();
            if (ena) j++;
            check_obs(j, ena, "ena");
            nbusy += busy;
        end
        ena = 1'b1;
        chk("ena.busy_total", nbusy, 16);

        // start+stop together in IDLE
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("ss.busy", busy, 0);
        chk("ss.sample", sample_out, 8'h80);
        chk("ss.valid", sample_valid, 0);

        // len=0, loop=1, div=1: same value, pulse every 2 clocks
        wr(4'd0, 8'd55); wr(4'd9, 8'd0); wr(4'd10, 8'd1); wr(4'd8, 8'd1);
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            chk("len0.sample", sample_out, 8'd55);
            chk("len0.idx", idx, 0);
            chk("len0.valid", sample_valid, k % 2 == 0);
        end

        // async reset mid-run
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst.sample", sample_out, 8'h80);
        chk("arst.busy", busy, 0);
        chk("arst.idx", idx, 0);
        step();
        rst_n = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        chk("arst.tbl0", sample_out, 8'h80);
        chk("arst.valid0", sample_valid, 1);
        chk("arst.busy0", busy, 1);
        step();
        chk("arst.idx1", idx, 1);
        chk("arst.tbl1", sample_out, 8'h80);
        chk("arst.valid1", sample_valid, 1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("arst.stop", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sigdel_seq.md
Name: sigdel_seq

Overview:
- Sample sequencer that feeds the 8-bit input of the sigma-delta modulator.
- Holds a small programmable pattern table plus config registers, written through a simple write-strobe port driven from the top-level pins.
- On start, plays the table out one entry at a time. Each entry is held for a programmable number of clocks (the modulator oversampling period).
- Supports one-shot or looped playback. Outputs a mid-scale idle code when not playing.

Parameters:
- DEPTH, 8, number of pattern entries; power of two.
- AW, 3, index width; log2(DEPTH).
- DW, 8, sample width; matches modulator input.
- DIVW, 8, hold-divider width.
- IDLE_CODE, 8'h80, sample driven while idle or stopped.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design enable; low freezes all sequential state except config writes.
- cfg_we  input  1  config write strobe; one write per cycle when high.
- cfg_addr  input  4  config address.
- cfg_data  input  DW  config write data.
- start  input  1  start playback (level sampled each cycle).
- stop  input  1  abort playback.
- sample_out  output  DW  sample to modulator input.
- sample_valid  output  1  one-cycle pulse when sample_out takes a new table value.
- busy  output  1  high in RUN.
- idx  output  AW  index of the entry currently driven.
- done  output  1  one-cycle pulse on natural end of one-shot playback.

Behaviour:
- Reset (async, rst_n low):
  - outputs: sample_out=IDLE_CODE; sample_valid, busy, done, idx = 0.
  - table entries = IDLE_CODE; div=0; len=DEPTH-1; loop=0; state IDLE; hold counter 0.
- Config map:
  - addr 0..DEPTH-1: table entry.
  - addr 8: div (hold = div+1 clocks per entry).
  - addr 9: len (last index, low AW bits).
  - addr 10: bit0 = loop.
  - Other addresses: writes ignored.
  - Table writes are accepted in any state; a write to an entry takes effect at that entry's next fetch.
  - Writes to addr 8..10 are ignored while busy.
- FSM IDLE:
  - Drives IDLE_CODE.
  - start=1 and stop=0 at edge N -> at N+1: state RUN, idx=0, sample_out=table[0], sample_valid=1, busy=1, hold counter=0.
- FSM RUN, each enabled cycle:
  - If counter<div: counter increments.
  - Else counter resets to 0 and the sequencer advances.
  - Advance when idx<len: idx increments; sample_out=table[idx+1]; sample_valid pulses.
  - Advance when idx==len and loop=1: idx wraps to 0; sample_out=table[0]; sample_valid pulses.
  - Advance when idx==len and loop=0: state IDLE; sample_out=IDLE_CODE; busy=0; done=1 for one cycle; sample_valid=0.
  - Each entry is visible for exactly div+1 clocks. One-shot total = (len+1)*(div+1) clocks, from the cycle after start to the cycle busy falls.
- stop:
  - In RUN: next edge -> IDLE, sample_out=IDLE_CODE, busy=0, idx=0, no done pulse.
  - start and stop in the same cycle: stop wins.
  - In IDLE: no effect.
- start while busy: ignored; no restart.
- ena=0:
  - State, counter, idx and sample_out hold.
  - sample_valid and done are forced 0.
  - Config writes are still accepted.
  - Counting resumes when ena returns high.
- div=0: a new entry every clock; sample_valid is high continuously while in RUN.
- len=0: a single entry; with loop=1, sample_valid pulses every div+1 clocks on the same value.
- Reset asserted mid-playback: immediate return to reset values, table included.

Test Plan:
- Reset, then idle: sample_out=8'h80, busy=0, idx=0 for 20 cycles after rst_n rises.
- Write table[0..3]=10,20,30,40; div=2; len=3; loop=0; pulse start -> each value held 3 clocks in order with sample_valid at each change. After 12 clocks: busy=0, done pulse, sample_out=8'h80.
- Same table, loop=1, div=0 -> sequence 10,20,30,40,10,20,... one per clock. Assert stop mid-sequence -> next cycle sample_out=8'h80, busy=0, no done pulse.
- During RUN: write div=5 (ignored; period stays 3); write table[2]=99 before idx reaches 2 -> 99 is played; start pulse is ignored.
- Drop ena for 4 cycles while holding table[1] -> sample_out and idx freeze, no pulses. Playback then resumes with the remaining hold count intact; total run is 12+4 clocks.
- start and stop asserted together in IDLE -> stays IDLE. Assert rst_n low mid-run -> outputs reset asynchronously and table reads back as 8'h80 on the next playback.
